hilo_unit: RTL and testbench
============================

Name: hilo_unit

Overview:
- Source of the HI/LO values that the dual-issue writeback stage consumes for MFHI/MFLO.
- Executes MULT/MULTU/DIV/DIVU as multi-cycle operations; executes MTHI/MTLO as single-cycle writes.
- Owns the architectural HI and LO registers and exposes them as hi_rd/lo_rd.
- Accepts one command per cycle from the execute stage; the commit is squashable by a pipeline flush.

Parameters:
- MUL_CYCLES, 3, cycles from accept to done for MULT/MULTU (legal range 1..8).
- DIV_ITERS, 32, radix-2 iterations per divide (fixed to the word width; not intended for override).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  1  command present.
- req_ready  out  1  unit can accept a command (state IDLE).
- req_op  in  3  hilo_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- req_a  in  32  rs operand (dividend / multiplicand / MT source).
- req_b  in  32  rt operand (divisor / multiplier).
- flush  in  1  abort the in-flight operation and drop the current request.
- busy  out  1  multi-cycle operation in flight.
- done  out  1  one-cycle pulse in the HI/LO commit cycle of MULT/DIV.
- hi_rd  out  32  current HI.
- lo_rd  out  32  current LO.

Behaviour:
- Reset (asynchronous, any state): HI=LO=0, state=IDLE, counter=0, busy=0, done=0, req_ready=1.
- States: IDLE, MUL, DIV, FIX.
- Accept occurs when req_valid & req_ready & !flush at the clock edge.
- IDLE, MT* accepted: writes HI or LO at that edge. hi_rd/lo_rd show the new value the next cycle. State stays IDLE; no done, no busy.
- IDLE, MULT/MULTU accepted: latch operands, compute the 64-bit signed or unsigned product, go to MUL with counter=MUL_CYCLES-1.
- MUL: counter decrements each cycle. In the cycle where counter==0: done=1, HI/LO={product} at the end of that cycle, then IDLE.
- Multiply latency: done is high in cycle MUL_CYCLES after the accept edge.
- IDLE, DIV/DIVU accepted: latch |a| and |b| (signed) or raw values (unsigned); record quotient and remainder signs; go to DIV.
- DIV: 32 restoring iterations, one quotient bit per cycle, then FIX.
- FIX: apply signs. Quotient is negated when the operand signs differ; remainder takes the dividend's sign. done=1; LO=quotient, HI=remainder at the end of the cycle; then IDLE.
- Divide latency: done is high in cycle 33 after the accept edge.
- Divide by zero (no trap): restoring result with the sign fix-up applied.
  - DIVU: LO=0xFFFFFFFF, HI=dividend.
  - DIV: the same magnitudes, then sign-adjusted.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- busy=1 in MUL/DIV/FIX. req_ready=!busy; a request presented while busy is held by the issuer (the stage stalls).
- flush=1 in any state: next state IDLE, HI/LO unchanged, done forced 0 that cycle. A request in the same cycle is not accepted.
- flush has priority over the FIX commit, so a squashed divide never writes.
- Arithmetic is 32-bit with a 64-bit product and a 33-bit partial remainder; no overflow flags.

Optional Feature:
- HILO_BYPASS_EN defined: hi_rd/lo_rd combinationally forward the value being written in the same cycle (MT* accept, MUL final cycle, FIX). Same-cycle MF* sees the new value.
- Undefined: hi_rd/lo_rd are the registers only. The new value is visible one cycle after the write; hazard logic must stall MF* by one cycle.

Decomposition:
- Shared package (common.svh):
  - hilo_op_t enum.
  - hilo_req_t struct {valid, op, a, b}.
  - MUL_CYCLES default constant.
- Local to the module: hilo_state_t.
- One sub-module, div_iter: one radix-2 restoring step, unsigned, 32-bit.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next partial remainder and quotient.
  - Instantiated once and iterated by the FSM.

Test Plan:
- MULT a=0xFFFFFFFE, b=3: done in cycle 3, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands: HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2: req_ready=0 for 33 cycles, done in cycle 33, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=0x1234, b=0: LO=0xFFFFFFFF, HI=0x1234.
- MTHI 0xDEADBEEF in IDLE: hi_rd=0xDEADBEEF next cycle (same cycle with HILO_BYPASS_EN), no done. MTLO issued during DIV: held until req_ready=1, then applied after the divide commits.
- DIV in flight, flush at cycle 10: done never asserts, HI/LO keep their prior values, req_ready=1 next cycle, and a new MULT is accepted and completes normally.
- flush in the FIX cycle: no commit. flush together with a req_valid MTHI in IDLE: HI unchanged.
- reset driven 0 mid-divide, asynchronously between edges: HI=LO=0, busy=0, done=0 immediately. Release, then DIVU 100/7: LO=14, HI=2.

Source files
------------

// File: rtl/hilo_unit_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation encoding,
// request bundle and the default multiply latency.
package hilo_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } hilo_op_t;

  typedef struct packed {
    logic        valid;
    hilo_op_t    op;
    logic [31:0] a;
    logic [31:0] b;
  } hilo_req_t;

  localparam int MUL_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/hilo_unit_div_iter.sv
// One radix-2 restoring division step on unsigned 32-bit values; the
// quotient register doubles as the dividend shift source.
module hilo_unit_div_iter (
  input  logic [31:0] rem_in,
  input  logic [31:0] quo_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic [31:0] quo_out
);

  logic [32:0] shifted;
  logic        ge;

  // When the subtraction succeeds the true difference fits in 32 bits,
  // so a 32-bit modular subtract gives the exact remainder.
  assign shifted = {rem_in, quo_in[31]};
  assign ge      = shifted >= {1'b0, divisor};
  assign rem_out = ge ? (shifted[31:0] - divisor) : shifted[31:0];
  assign quo_out = {quo_in[30:0], ge};

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register owner executing MULT/MULTU/DIV/DIVU (multi-cycle) and MTHI/MTLO.
// Optional macro HILO_BYPASS_EN forwards same-cycle writes onto hi_rd/lo_rd.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int DIV_ITERS  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  hilo_op_t    req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_rd,
  output logic [31:0] lo_rd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } hilo_state_t;

  localparam int CNT_W = 6;

  hilo_state_t      state;
  hilo_req_t        req;
  logic [CNT_W-1:0] counter;
  logic             busy_r;
  logic             done_r;
  logic             accept;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [63:0]      prod;
  logic [31:0]      rem;
  logic [31:0]      quo;
  logic [31:0]      divisor;
  logic             q_neg;
  logic             r_neg;
  logic [31:0]      rem_next;
  logic [31:0]      quo_next;

  logic             div_signed;
  logic [31:0]      abs_a;
  logic [31:0]      abs_b;
  logic [63:0]      mul_prod;

  logic             hi_we;
  logic             lo_we;
  logic [31:0]      hi_wdata;
  logic [31:0]      lo_wdata;

  assign req       = '{valid: req_valid, op: req_op, a: req_a, b: req_b};
  assign req_ready = ~busy_r;
  assign busy      = busy_r;
  assign done      = done_r & ~flush;
  assign accept    = req.valid & req_ready & ~flush;

  hilo_unit_div_iter u_div_iter (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (divisor),
    .rem_out (rem_next),
    .quo_out (quo_next)
  );

  // Operand preparation: sign-extended 64-bit operands give the correct
  // signed product from a plain modular multiply.
  always_comb begin
    div_signed = (req.op == OP_DIV);
    abs_a      = (div_signed && req.a[31]) ? -req.a : req.a;
    abs_b      = (div_signed && req.b[31]) ? -req.b : req.b;
    if (req.op == OP_MULT)
      mul_prod = {{32{req.a[31]}}, req.a} * {{32{req.b[31]}}, req.b};
    else
      mul_prod = {32'b0, req.a} * {32'b0, req.b};
  end

  // HI/LO write port; flush suppresses every commit, including FIX.
  always_comb begin
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    hi_wdata = hi;
    lo_wdata = lo;
    if (!flush) begin
      case (state)
        S_IDLE: begin
          if (accept && req.op == OP_MTHI) begin
            hi_we    = 1'b1;
            hi_wdata = req.a;
          end
          if (accept && req.op == OP_MTLO) begin
            lo_we    = 1'b1;
            lo_wdata = req.a;
          end
        end
        S_MUL: begin
          if (counter == '0) begin
            hi_we    = 1'b1;
            lo_we    = 1'b1;
            hi_wdata = prod[63:32];
            lo_wdata = prod[31:0];
          end
        end
        S_FIX: begin
          hi_we    = 1'b1;
          lo_we    = 1'b1;
          hi_wdata = r_neg ? -rem : rem;
          lo_wdata = q_neg ? -quo : quo;
        end
        default: ;
      endcase
    end
  end

`ifdef HILO_BYPASS_EN
  assign hi_rd = hi_we ? hi_wdata : hi;
  assign lo_rd = lo_we ? lo_wdata : lo;
`else
  assign hi_rd = hi;
  assign lo_rd = lo;
`endif

  // Control FSM; done_r is raised one edge ahead so it is high exactly in
  // the commit cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      counter <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      prod    <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      if (hi_we) hi <= hi_wdata;
      if (lo_we) lo <= lo_wdata;
      done_r <= 1'b0;
      if (flush) begin
        state   <= S_IDLE;
        busy_r  <= 1'b0;
        counter <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              case (req.op)
                OP_MULT, OP_MULTU: begin
                  prod    <= mul_prod;
                  counter <= CNT_W'(MUL_CYCLES - 1);
                  busy_r  <= 1'b1;
                  done_r  <= (MUL_CYCLES == 1);
                  state   <= S_MUL;
                end
                OP_DIV, OP_DIVU: begin
                  rem     <= '0;
                  quo     <= abs_a;
                  divisor <= abs_b;
                  q_neg   <= div_signed & (req.a[31] ^ req.b[31]);
                  r_neg   <= div_signed & req.a[31];
                  counter <= CNT_W'(DIV_ITERS - 1);
                  busy_r  <= 1'b1;
                  state   <= S_DIV;
                end
                default: ;
              endcase
            end
          end
          S_MUL: begin
            if (counter == '0) begin
              busy_r <= 1'b0;
              state  <= S_IDLE;
            end else begin
              counter <= counter - 1'b1;
              done_r  <= (counter == CNT_W'(1));
            end
          end
          S_DIV: begin
            rem <= rem_next;
            quo <= quo_next;
            if (counter == '0) begin
              done_r <= 1'b1;
              state  <= S_FIX;
            end else begin
              counter <= counter - 1'b1;
            end
          end
          S_FIX: begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: stimulus pushes expected HI/LO and latency,
// an independent monitor pops and checks on every done pulse.
module tb_hilo_unit;
  import hilo_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  hilo_op_t    req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi_rd;
  logic [31:0] lo_rd;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          latency;
    int          accept_edge;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt     = 0;
  int   miscompares = 0;
  int   edge_cnt    = 0;
  int   last_accept = 0;

  hilo_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi_rd     (hi_rd),
    .lo_rd     (lo_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Issue one command, holding it while the unit is busy; returns just after the accept edge.
  task automatic applyStimulus(input hilo_op_t op, input logic [31:0] a, input logic [31:0] b);
    int waits;
    waits     = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    while (!req_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) begin
      vec_cnt++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: req_ready got %b expected 1", req_ready);
    end
    @(posedge clk);
    #1;
    last_accept = edge_cnt;
    req_valid   = 1'b0;
  endtask

  task automatic pushExpect(input string name, input logic [31:0] hi, input logic [31:0] lo, input int latency);
    exp_t e;
    e.hi          = hi;
    e.lo          = lo;
    e.latency     = latency;
    e.accept_edge = last_accept;
    e.name        = name;
    exp_q.push_back(e);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      vec_cnt++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    int   done_edge;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && done === 1'b1) begin
        done_edge = edge_cnt;
        if (exp_q.size() == 0) begin
          vec_cnt++;
          miscompares++;
          $display("[TB] FAIL unexpected_done: done got 1 expected 0 at edge %0d", done_edge);
        end else begin
          e = exp_q.pop_front();
          @(posedge clk);
          #1;
          checkOutput({e.name, "_hi"}, hi_rd, e.hi);
          checkOutput({e.name, "_lo"}, lo_rd, e.lo);
          checkOutput({e.name, "_latency"}, 32'(done_edge - e.accept_edge + 1), 32'(e.latency));
        end
      end
    end
  end

  initial begin
    int div_accept;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = OP_MULT;
    req_a     = '0;
    req_b     = '0;
    flush     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hi", hi_rd, 32'h0);
    checkOutput("reset_lo", lo_rd, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_done", {31'b0, done}, 32'h0);
    checkOutput("reset_ready", {31'b0, req_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'd3);
    pushExpect("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFFA, 3);
    waitDrain();
    applyStimulus(OP_MULTU, 32'hFFFFFFFE, 32'd3);
    pushExpect("multu", 32'h00000002, 32'hFFFFFFFA, 3);
    waitDrain();

    // Signed divide with an MTLO queued behind it while busy.
    applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2);
    pushExpect("div_neg7_2", 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    div_accept = last_accept;
    applyStimulus(OP_MTLO, 32'h0BADF00D, 32'h0);
    checkOutput("mtlo_held_gap", 32'(last_accept - div_accept), 32'd34);
    checkOutput("mtlo_after_div_lo", lo_rd, 32'h0BADF00D);
    checkOutput("mtlo_after_div_hi", hi_rd, 32'hFFFFFFFF);
    waitDrain();

    applyStimulus(OP_DIVU, 32'h00001234, 32'h0);
    pushExpect("divu_by_zero", 32'h00001234, 32'hFFFFFFFF, 33);
    waitDrain();
    applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    pushExpect("div_min_neg1", 32'h00000000, 32'h80000000, 33);
    waitDrain();

    applyStimulus(OP_MTHI, 32'hDEADBEEF, 32'h0);
    checkOutput("mthi_hi", hi_rd, 32'hDEADBEEF);
    checkOutput("mthi_busy", {31'b0, busy}, 32'h0);
    checkOutput("mthi_done", {31'b0, done}, 32'h0);

    // Flush a divide in its tenth cycle, then run a multiply.
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_div_ready", {31'b0, req_ready}, 32'h1);
    checkOutput("flush_div_hi", hi_rd, 32'hDEADBEEF);
    checkOutput("flush_div_lo", lo_rd, 32'h80000000);
    repeat (40) @(posedge clk);
    #1;
    applyStimulus(OP_MULT, 32'd7, 32'd6);
    pushExpect("mult_after_flush", 32'h0, 32'd42, 3);
    waitDrain();

    // Flush landing on the FIX cycle must suppress the commit.
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    repeat (32) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_fix_busy", {31'b0, busy}, 32'h0);
    checkOutput("flush_fix_hi", hi_rd, 32'h0);
    checkOutput("flush_fix_lo", lo_rd, 32'd42);
    repeat (3) @(posedge clk);
    #1;

    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = OP_MTHI;
    req_a     = 32'h11111111;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    checkOutput("flush_mthi_hi", hi_rd, 32'h0);

    // Asynchronous reset between edges in the middle of a divide.
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_hi", hi_rd, 32'h0);
    checkOutput("async_reset_lo", lo_rd, 32'h0);
    checkOutput("async_reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("async_reset_done", {31'b0, done}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    pushExpect("divu_100_7", 32'd2, 32'd14, 33);
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
